fir_deconv: RTL

- Inverse (receiver-side) filter for the team's 4-tap FIR encoder: y[n] = H0*x[n] + H1*x[n-1] + H2*x[n-2] + H3*x[n-3].
- Takes the encoder's 10-bit output samples and recovers the original 4-bit input stream by recursive subtraction of the weighted history. H0 is fixed at 1, so no divider is needed.
- Sits downstream of the FIR on the same sample stream. Adds valid/ready handshaking, range checking and lock tracking so the link can be self-checked on the board.

---
 rtl/fir_deconv.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fir_deconv.sv
// Receiver-side inverse of the 4-tap FIR encoder.
// Recovers the 4-bit source stream from 10-bit encoded samples by subtracting
// the weighted history of previously decoded samples (H0 = 1, so no divide).
// A single-entry output register provides valid/ready flow control; decoded
// values are clamped to 0..15, flagged when out of range, counted, and used
// to track whether the link is aligned.
module fir_deconv #(
  parameter int unsigned H1       = 2,
  parameter int unsigned H2       = 3,
  parameter int unsigned H3       = 4,
  parameter int unsigned LOCK_RUN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [9:0] q_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] x_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       range_err,
  output logic [7:0] err_cnt,
  output logic       locked
);

  localparam logic [3:0] H1_C  = 4'(H1);
  localparam logic [3:0] H2_C  = 4'(H2);
  localparam logic [3:0] H3_C  = 4'(H3);
  localparam logic [3:0] RUN_C = 4'(LOCK_RUN);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Decoded history: x1 is the most recent recovered sample.
  logic [3:0]  x1_q, x2_q, x3_q;
  logic [3:0]  x_out_q;
  logic        out_valid_q;
  logic        range_err_q;
  logic [7:0]  err_cnt_q;
  lock_state_e state_q;
  logic [3:0]  run_q;

  logic        accept;
  logic [7:0]  p1, p2, p3;
  logic [11:0] r;
  logic        r_low, r_high, sample_err;
  logic [3:0]  d;

  // Single-entry output register: room exists when empty or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Residual after removing weighted history, then clamp to the 4-bit range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    d  = 4'h0;
    // Products are at most 15*15 = 225, so 8 bits hold them exactly.
    p1 = {4'h0, H1_C} * {4'h0, x1_q};
    p2 = {4'h0, H2_C} * {4'h0, x2_q};
    p3 = {4'h0, H3_C} * {4'h0, x3_q};
    // Residual spans -675..1023; bit 11 is its sign in two's complement.
    r  = {2'b00, q_in} - {4'h0, p1} - {4'h0, p2} - {4'h0, p3};
    r_low      = r[11];
    r_high     = !r[11] && (r[10:4] != 7'd0);
    sample_err = r_low || r_high;
    if (r_high)     d = 4'hF;
    else if (!r_low) d = r[3:0];
  end

  // Output register, history shift, error pulse and saturating error count.
  // NOTE: reset clears every register asynchronously; flush is the
  // synchronous clear and wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q        <= 4'h0;
      x2_q        <= 4'h0;
      x3_q        <= 4'h0;
      x_out_q     <= 4'h0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else if (flush) begin
      x1_q        <= 4'h0;
      x2_q        <= 4'h0;
      x3_q        <= 4'h0;
      x_out_q     <= 4'h0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values, giving the intended shift behaviour.
      range_err_q <= accept && sample_err;
      if (accept) begin
        x_out_q     <= d;
        out_valid_q <= 1'b1;
        x3_q        <= x2_q;
        x2_q        <= x1_q;
        x1_q        <= d;
        if (sample_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Lock tracker: LOCK_RUN consecutive in-range accepts lock, any error unlocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      run_q   <= 4'h0;
    end else if (flush) begin
      state_q <= UNLOCKED;
      run_q   <= 4'h0;
    end else if (accept) begin
      case (state_q)
        UNLOCKED: begin
          if (sample_err) begin
            run_q <= 4'h0;
          end else begin
            run_q <= run_q + 4'd1;
            if (run_q + 4'd1 == RUN_C) state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (sample_err) begin
            state_q <= UNLOCKED;
            run_q   <= 4'h0;
          end
        end
        default: begin
          state_q <= UNLOCKED;
          run_q   <= 4'h0;
        end
      endcase
    end
  end

  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;
  assign range_err = range_err_q;
  assign err_cnt   = err_cnt_q;
  assign locked    = (state_q == LOCKED);

endmodule
